icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Parametrised direct-mapped instruction cache with its own refill state machine; sits between the fetch-stage PC and instruction memory.
- Lookup is combinational. On a miss, the block fetches the line one word per memory beat over a req/ack handshake, then installs the line and reports a hit.
- Replaces the wide 8-word single-cycle fill with a narrow multi-beat refill and adds flush support.

Parameters:
- NUM_SETS, 16, number of cache lines (power of 2, ≥2)
- WORDS_PER_BLOCK, 8, 32-bit words per line (power of 2, ≥2)
- NOP_INSTR, 32'h00000013, value driven on rd when not hit
- Derived: IDX_W=log2(NUM_SETS), OFF_W=log2(WORDS_PER_BLOCK), TAG_W=32-IDX_W-OFF_W-2

Ports:
- CLK  in  1  clock; all state updates on posedge CLK
- RST  in  1  synchronous active-high reset
- PC  in  32  fetch address; byte offset PC[1:0] ignored
- flush  in  1  invalidate all lines (e.g. after fence.i)
- rd  out  32  instruction word at PC when hit, else NOP_INSTR
- hit  out  1  valid line with tag match at PC
- stall  out  1  = !hit; fetch must hold PC
- mem_req  out  1  refill beat request
- mem_addr  out  32  word-aligned address of the current beat
- mem_ack  in  1  memory accepts the request; mem_rdata valid in the same cycle
- mem_rdata  in  32  refill data word

Behaviour:
- Address split: offset=PC[OFF_W+1:2], index=PC[IDX_W+OFF_W+1:OFF_W+2], tag=PC[31:IDX_W+OFF_W+2].
- hit = valid[index] && tags[index]==tag && state==IDLE. Combinational from PC; zero-cycle latency.
- rd = data[index][offset] when hit, else NOP_INSTR.
- Reset values:
  - all valid bits 0; state IDLE; mem_req 0; mem_addr 0; beat counter 0
  - rd=NOP_INSTR; hit=0; stall=1
  - data and tag arrays are not reset
- States:
  - IDLE:
    - If !hit && !flush: latch fill_tag/fill_idx from PC, set beat=0, go REFILL.
    - mem_req goes high the next cycle.
  - REFILL:
    - mem_req=1; mem_addr={fill_tag, fill_idx, beat, 2'b00}.
    - On mem_ack: write mem_rdata to data[fill_idx][beat], then beat++.
    - If beat==WORDS_PER_BLOCK-1 on that ack: write tags[fill_idx]=fill_tag, set valid[fill_idx]=1, go DONE.
    - Without mem_ack: hold all outputs and the beat counter (stall indefinitely).
  - DONE:
    - mem_req=0; one bubble cycle; go IDLE.
    - hit is evaluated again against the current PC.
- Miss penalty: 1 (IDLE→REFILL) + WORDS_PER_BLOCK ack cycles + 1 (DONE). With mem_ack tied high and defaults, a miss returns a hit 10 cycles after PC is presented.
- PC changing during REFILL is ignored; the latched line completes and the lookup re-evaluates in IDLE.
- Beat counter is OFF_W bits and wraps to 0 after the last beat; no partial line is ever marked valid.
- The refill overwrites any previously valid line at fill_idx. valid[fill_idx] is cleared on entry to REFILL, so a stale line is never returned.
- Flush:
  - In any state, clears all valid bits and goes IDLE next cycle; mem_req drops next cycle.
  - In REFILL, the fill is aborted and the line is left invalid.
  - A flush coinciding with the final ack also wins: the line is left invalid.
- RST mid-refill: same as reset values. mem_req deasserts on the next edge; any in-flight ack is ignored.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0]. Both reset to 0 on RST; flush does not clear them.
  - hit_count increments each IDLE cycle with hit=1.
  - miss_count increments once per IDLE→REFILL transition.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: after RST, PC=0x00000040, mem_ack=1, mem_rdata=addr+0x1000.
  - Expect mem_addr sequence 0x40,0x44,…,0x5C.
  - Expect hit=1 at cycle 10 and rd=0x00001040.
  - Expect rd=NOP (0x00000013) and stall=1 before that.
- Sequential hits: after the fill above, PC=0x44..0x5C each cycle → hit=1 every cycle, rd=0x00001044..0x0000105C, mem_req=0 throughout.
- Conflict eviction: fill PC=0x40, then PC=0x240 (same index 2, different tag).
  - Expect a refill, then hit at 0x240.
  - Returning to PC=0x40 gives miss and a refill.
- Ack backpressure: mem_ack toggles 1,0,0,1…
  - Expect mem_addr to hold during low ack; exactly 8 writes; hit only after the 8th ack.
- Flush mid-refill: flush=1 on the 4th beat of the PC=0x80 fill.
  - Expect mem_req=0 next cycle and hit=0.
  - Expect a fresh refill from 0x80 afterwards; a previously filled line at 0x40 also misses.
- Reset mid-refill and perf counters (ICACHE_PERF_CNT_EN): RST on beat 3.
  - Expect mem_req=0 next cycle, all lines invalid, and counters 0.
  - Then one miss plus 5 hits gives miss_count=1, hit_count=5.

Source files
------------

// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with a multi-beat refill engine.
// Lookup is combinational and takes zero cycles. On a miss, the line is fetched
// one 32-bit word per memory beat. The line is marked valid only after its last beat.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   PC                  fetch address; PC[1:0] is ignored
//   flush               invalidates all lines and aborts any refill in progress
//   rd, hit, stall      lookup result (combinational from PC)
//   mem_req, mem_addr   refill beat request and word-aligned beat address (registered)
//   mem_ack, mem_rdata  beat accept; the data is valid in the same cycle
//   hit_count, miss_count   saturating performance counters, present only when
//                           ICACHE_PERF_CNT_EN is defined
module icache_refill #(
    parameter int unsigned NUM_SETS        = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic [31:0] rd,
    output logic        hit,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]   tag_mem  [NUM_SETS];
    logic [31:0]        data_mem [NUM_SETS][WORDS_PER_BLOCK];
    logic [TAG_W-1:0]   fill_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [OFF_W-1:0]   beat;
    logic [OFF_W-1:0]   beat_nxt;
    logic               last_beat;

    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               unused_pc;

    assign pc_off    = PC[OFF_W+1:2];
    assign pc_idx    = PC[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag    = PC[31:IDX_W+OFF_W+2];
    assign unused_pc = ^PC[1:0];

    assign beat_nxt  = beat + OFF_W'(1);
    assign last_beat = (beat == OFF_W'(WORDS_PER_BLOCK - 1));

    // Lookup: a hit is reported only in IDLE, so a refill in flight never returns data.
    assign hit   = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag) && (state == IDLE);
    assign rd    = hit ? data_mem[pc_idx][pc_off] : NOP_INSTR;
    assign stall = !hit;

    // Control FSM. Flush takes priority over every state, including the final ack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            valid    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            beat     <= '0;
            fill_tag <= '0;
            fill_idx <= '0;
        end else if (flush) begin
            state    <= IDLE;
            valid    <= '0;
            mem_req  <= 1'b0;
            beat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        fill_tag       <= pc_tag;
                        fill_idx       <= pc_idx;
                        beat           <= '0;
                        valid[pc_idx]  <= 1'b0;  // the old line is being overwritten
                        mem_req        <= 1'b1;
                        mem_addr       <= {pc_tag, pc_idx, {OFF_W{1'b0}}, 2'b00};
                        state          <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        beat     <= beat_nxt;
                        mem_addr <= {fill_tag, fill_idx, beat_nxt, 2'b00};
                        if (last_beat) begin
                            valid[fill_idx] <= 1'b1;
                            mem_req         <= 1'b0;
                            state           <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Data and tag storage. These arrays are not reset; validity lives in valid[].
    always_ff @(posedge CLK) begin
        if (!RST && (state == REFILL) && mem_ack) begin
            data_mem[fill_idx][beat] <= mem_rdata;
            if (last_beat) begin
                tag_mem[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating counters. A flush does not clear them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state == IDLE) && !hit && !flush && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill. Memory returns mem_addr + 0x1000 for every beat.
module tb_icache_refill;

    logic        CLK;
    logic        RST;
    logic [31:0] PC;
    logic        flush;
    logic [31:0] rd;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    icache_refill dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC        (PC),
        .flush     (flush),
        .rd        (rd),
        .hit       (hit),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    assign mem_rdata = mem_addr + 32'h0000_1000;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advance until hit is seen or the budget expires; n is the number of edges taken.
    task automatic wait_hit(input int max_cyc, output int n);
        n = 0;
        while (!hit && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acks;
        int c;
        bit got;

        RST = 1'b1; PC = 32'h0; flush = 1'b0; mem_ack = 1'b0;
        repeat (2) tick();

        // Reset values
        chk_eq("rst_hit",   32'(hit),     32'd0);
        chk_eq("rst_stall", 32'(stall),   32'd1);
        chk_eq("rst_rd",    rd,           32'h0000_0013);
        chk_eq("rst_req",   32'(mem_req), 32'd0);
        chk_eq("rst_addr",  mem_addr,     32'h0);
`ifdef ICACHE_PERF_CNT_EN
        chk_eq("rst_hcnt", hit_count,  32'd0);
        chk_eq("rst_mcnt", miss_count, 32'd0);
`endif
        RST = 1'b0;

        // Cold miss at 0x40 with ack tied high: hit exactly 10 cycles later
        PC = 32'h40; mem_ack = 1'b1; #1;
        chk_eq("cold_c0_hit", 32'(hit),     32'd0);
        chk_eq("cold_c0_rd",  rd,           32'h0000_0013);
        chk_eq("cold_c0_req", 32'(mem_req), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_eq("cold_req",   32'(mem_req), 32'd1);
            chk_eq("cold_addr",  mem_addr,     32'h40 + 32'(4 * (k - 1)));
            chk_eq("cold_stall", 32'(stall),   32'd1);
            chk_eq("cold_rd",    rd,           32'h0000_0013);
        end
        tick();
        chk_eq("cold_c9_hit", 32'(hit),     32'd0);
        chk_eq("cold_c9_req", 32'(mem_req), 32'd0);
        tick();
        chk_eq("cold_c10_hit",   32'(hit),   32'd1);
        chk_eq("cold_c10_stall", 32'(stall), 32'd0);
        chk_eq("cold_c10_rd",    rd,         32'h0000_1040);

        // Sequential hits across the filled line
        for (int k = 1; k < 8; k++) begin
            tick();
            PC = 32'h40 + 32'(4 * k); #1;
            chk_eq("seq_hit", 32'(hit),     32'd1);
            chk_eq("seq_rd",  rd,           32'h1040 + 32'(4 * k));
            chk_eq("seq_req", 32'(mem_req), 32'd0);
        end

        // Conflict eviction on index 2
        tick();
        PC = 32'h240; #1;
        chk_eq("conf_miss", 32'(hit), 32'd0);
        wait_hit(40, n);
        chk_eq("conf_lat", 32'(n),    32'd10);
        chk_eq("conf_hit", 32'(hit),  32'd1);
        chk_eq("conf_rd",  rd,        32'h0000_1240);
        PC = 32'h40; #1;
        chk_eq("evict_miss", 32'(hit), 32'd0);
        wait_hit(40, n);
        chk_eq("evict_lat", 32'(n), 32'd10);
        chk_eq("evict_rd",  rd,     32'h0000_1040);

        // Ack backpressure 1,0,0,1,... on a fill of 0x80
        PC = 32'h80; mem_ack = 1'b0; #1;
        chk_eq("bp_miss", 32'(hit), 32'd0);
        acks = 0; c = 0; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (hit) begin
                got = 1'b1;
                chk_eq("bp_acks", 32'(acks), 32'd8);
                chk_eq("bp_lat",  32'(i + 1), 32'd24);
                chk_eq("bp_rd",   rd,         32'h0000_1080);
            end else if (mem_req) begin
                chk_eq("bp_addr", mem_addr, 32'h80 + 32'(4 * acks));
                mem_ack = (c % 3 == 0);
                if (mem_ack) acks++;
                c++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        chk_eq("bp_done", 32'(got), 32'd1);
        mem_ack = 1'b1;

        // Flush while idle invalidates the 0x80 line without starting a refill
        #1;
        chk_eq("fl_pre_hit", 32'(hit), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        chk_eq("fl_idle_hit", 32'(hit),     32'd0);
        chk_eq("fl_idle_req", 32'(mem_req), 32'd0);

        // Flush on the 4th beat of the 0x80 refill aborts the fill
        repeat (4) tick();
        chk_eq("fl_beat4_addr", mem_addr, 32'h0000_008C);
        flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        chk_eq("fl_abort_req", 32'(mem_req), 32'd0);
        chk_eq("fl_abort_hit", 32'(hit),     32'd0);
        tick();
        chk_eq("fl_restart_req",  32'(mem_req), 32'd1);
        chk_eq("fl_restart_addr", mem_addr,     32'h0000_0080);
        wait_hit(20, n);
        chk_eq("fl_refill_hit", 32'(hit), 32'd1);
        chk_eq("fl_refill_rd",  rd,       32'h0000_1080);
        PC = 32'h40; #1;
        chk_eq("fl_old_miss", 32'(hit), 32'd0);

        // Flush on the final ack leaves the line invalid
        repeat (8) tick();
        chk_eq("fl_last_addr", mem_addr, 32'h0000_005C);
        flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        chk_eq("fl_last_hit", 32'(hit),     32'd0);
        chk_eq("fl_last_req", 32'(mem_req), 32'd0);

        // Reset on beat 3 of the 0x40 refill
        repeat (4) tick();
        chk_eq("rst_mid_addr", mem_addr, 32'h0000_004C);
        RST = 1'b1;
        tick();
        RST = 1'b0; PC = 32'h80; #1;
        chk_eq("rst_mid_req",  32'(mem_req), 32'd0);
        chk_eq("rst_mid_hit",  32'(hit),     32'd0);
        chk_eq("rst_mid_addr0", mem_addr,    32'h0);
`ifdef ICACHE_PERF_CNT_EN
        chk_eq("rst_mid_hcnt", hit_count,  32'd0);
        chk_eq("rst_mid_mcnt", miss_count, 32'd0);
`endif
        wait_hit(40, n);
        chk_eq("post_rst_lat", 32'(n), 32'd10);
        chk_eq("post_rst_rd",  rd,     32'h0000_1080);
        repeat (5) tick();
        chk_eq("post_rst_hold", 32'(hit), 32'd1);
`ifdef ICACHE_PERF_CNT_EN
        chk_eq("perf_hcnt", hit_count,  32'd5);
        chk_eq("perf_mcnt", miss_count, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
